mem_stream_reader: RTL

Read-side sequencer for the team's preloaded dual-port stub memories (registered read, one-cycle latency). On a start command it walks one memory page, issuing `READ_ADD` and capturing the returned words. It streams them out over a valid/ready interface with `OUT_LAST` on the final entry, and absorbs downstream backpressure without losing in-flight read data. It sits between a memory's read port and the next processing stage of the tracklet chain.

---
 rtl/mem_stream_reader_pkg.sv | 19 +
 rtl/mem_stream_reader_skid_fifo2.sv | 61 ++++++
 rtl/mem_stream_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the page-walking memory stream reader: default widths
// matching the stub memories, the sequencer state encoding and index-width helper.
package mem_stream_reader_pkg;

  localparam int DEF_RAM_WIDTH     = 36;
  localparam int DEF_RAM_ADDR_BITS = 9;
  localparam int DEF_PAGE_BITS     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int idx_bits(input int addr_bits, input int page_bits);
    return addr_bits - page_bits;
  endfunction

endpackage

// File: rtl/mem_stream_reader_skid_fifo2.sv
// Two-entry FIFO carrying a data word plus a last flag. Slot 0 is always the
// head, so the head outputs come straight from registers.
module skid_fifo2 #(
  parameter int W = 36
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic [1:0]   count
);

  logic [W-1:0] data1;
  logic         last1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_data <= '0;
      head_last <= 1'b0;
      data1     <= '0;
      last1     <= 1'b0;
      count     <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            data1 <= push_data;
            last1 <= push_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= data1;
          head_last <= last1;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever survives the pop.
          if (count == 2'd2) begin
            head_data <= data1;
            head_last <= last1;
            data1     <= push_data;
            last1     <= push_last;
          end else begin
            head_data <= push_data;
            head_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Walks one page of a registered-read memory on START and streams the words out
// over valid/ready, tagging the final entry with OUT_LAST.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter int PAGE_BITS     = DEF_PAGE_BITS,
  localparam int IDX_BITS     = idx_bits(RAM_ADDR_BITS, PAGE_BITS)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic [PAGE_BITS-1:0]     PAGE,
  input  logic [IDX_BITS:0]        NENT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [RAM_ADDR_BITS-1:0] READ_ADD,
  input  logic [RAM_WIDTH-1:0]     RAM_DATA,
  output logic [RAM_WIDTH-1:0]     OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     OUT_LAST,
  output logic [1:0]               DBG_STATE
);

  // Stream handshake: a word moves on a rising edge where OUT_VALID and
  // OUT_READY are both high; OUT_VALID never depends on OUT_READY, and
  // OUT_DATA/OUT_LAST hold steady while OUT_VALID=1 and OUT_READY=0.

  state_t                 state;
  logic [PAGE_BITS-1:0]   page_q;
  logic [IDX_BITS-1:0]    idx_q;
  logic [IDX_BITS-1:0]    idx_nxt;
  logic [IDX_BITS-1:0]    last_idx_q;
  logic                   pending;
  logic                   pending_last;
  logic [1:0]             fifo_count;
  logic [RAM_WIDTH-1:0]   head_data;
  logic                   head_last;
  logic                   pop;
  logic [2:0]             credit_after;
  logic                   issue;
  logic                   issue_last;

  assign OUT_VALID = (fifo_count != 2'd0);
  assign OUT_DATA  = head_data;
  assign OUT_LAST  = head_last & OUT_VALID;
  assign DBG_STATE = state;
  assign pop       = OUT_VALID & OUT_READY;

  // FIFO words plus the read in flight, after this edge's pop, must stay below
  // two so a stalled consumer never loses returned data.
  assign credit_after = {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};
  assign issue        = (state == ST_READ) && (credit_after < 3'd2);
  assign issue_last   = issue && (idx_q == last_idx_q);
  assign idx_nxt      = idx_q + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      page_q       <= '0;
      idx_q        <= '0;
      last_idx_q   <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      READ_ADD     <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      DONE         <= 1'b0;
      pending      <= issue;
      pending_last <= issue_last;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            if (NENT != '0) begin
              state      <= ST_READ;
              page_q     <= PAGE;
              idx_q      <= '0;
              last_idx_q <= NENT[IDX_BITS-1:0] - 1'b1;
              READ_ADD   <= {PAGE, {IDX_BITS{1'b0}}};
              BUSY       <= 1'b1;
            end else begin
              DONE <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            idx_q    <= idx_nxt;
            READ_ADD <= {page_q, idx_nxt};
            if (issue_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  skid_fifo2 #(.W(RAM_WIDTH)) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (pending),
    .push_data (RAM_DATA),
    .push_last (pending_last),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .count     (fifo_count)
  );

endmodule
